// File: rtl/mult_4bit_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Provides the FSM state encoding and the default operand width.
package mult_4bit_seq_pkg;

   localparam int MULT_WIDTH = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_4bit_seq_add4_cout.sv
// Combinational adder with carry-out, used once per iteration to add the
// partial product into the upper product half.
// Ports:
//   A, B : addends
//   SUM  : A + B truncated to WIDTH bits
//   COUT : carry out of the top bit
module add4_cout #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);

   assign {COUT, SUM} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/mult_4bit_seq.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
// One add plus a right shift of {ACC,Q} per cycle over WIDTH cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   start : request; sampled only in IDLE or DONE
//   A, B  : multiplicand / multiplier, captured on the accepted start edge
//   busy  : high while iterating
//   done  : one-cycle pulse when P updates
//   P     : product, held until the next completion
//
// state  | meaning
// IDLE   | waiting for start, P holds last result
// RUN    | iterating, start ignored
// DONE   | one-cycle completion, start accepted back-to-back
module mult_4bit_seq
   import mult_4bit_seq_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] P
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] p_q, p_d;

   logic [WIDTH-1:0]   pp;
   logic [WIDTH-1:0]   sum;
   logic               cout;

   assign pp = q_q[0] ? m_q : '0;

   add4_cout #(.WIDTH(WIDTH)) u_add (
      .A    (acc_q),
      .B    (pp),
      .SUM  (sum),
      .COUT (cout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               m_d     = A;
               q_d     = B;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // Carry shifts into the top of ACC so nothing is lost.
            acc_d = {cout, sum[WIDTH-1:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               p_d     = {acc_d, q_d};
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign P    = p_q;

endmodule
